// File: rtl/sync_fifo_if.sv
// sync_fifo_if -- handshake and status bundle for sync_fifo.
//
// Parameters mirror the FIFO so widths line up:
//   DATA_WIDTH  word width
//   FIFO_DEPTH  entries; count is clog2(FIFO_DEPTH+1) bits wide
//
// Signals:
//   wr_en, wr_data            write request and word        (master -> slave)
//   rd_en                     read request                  (master -> slave)
//   rd_data, rd_valid         read word and its qualifier   (slave -> master)
//   full, empty,
//   almost_full, almost_empty registered status flags       (slave -> master)
//   count                     occupancy                     (slave -> master)
//   overflow, underflow       one-cycle rejected-op pulses  (slave -> master)
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 90
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO of arbitrary (non power-of-two) depth.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (deassert synchronously to clk)
//   bus    sync_fifo_if.slave: wr_en/wr_data/rd_en in; rd_data, rd_valid,
//          full, empty, almost_full, almost_empty, count, overflow,
//          underflow out
//
// Build option:
//   SYNC_FIFO_FWFT_EN  first-word-fall-through. rd_data presents the head
//                      word whenever the FIFO is non-empty and rd_valid is
//                      !empty; rd_en pops the head on the edge.
//                      Undefined: rd_data is loaded on the accepting edge and
//                      rd_valid pulses for one cycle after it.
//
// All status outputs are registered from the next-state occupancy, so they
// line up with count in the cycle after the edge that changes it. The
// storage array has no reset; stale words are unreachable because reset
// returns both pointers and count to zero.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 90,
  parameter int AFULL_LVL  = FIFO_DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);
  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, udf_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the registered flags: a full FIFO still accepts the
  // read half of a simultaneous request, an empty one the write half.
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  // Explicit wrap at FIFO_DEPTH-1 so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= (AEMPTY_LVL >= 0);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (int'(count_d) >= AFULL_LVL);
      aempty_q <= (int'(count_d) <= AEMPTY_LVL);
      ovf_q    <= bus.wr_en && full_q;
      udf_q    <= bus.rd_en && empty_q;
    end
  end

  // Storage: no reset, written only on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // rd_data_q always holds the head word. It reloads when the head moves
  // (a pop) or when a write lands in an empty FIFO. If nothing is left
  // after the pop the new head is this cycle's write word, which is not
  // in the array yet, so it is taken straight from wr_data.
  logic [CW-1:0]         left;
  logic [DATA_WIDTH-1:0] head_d;
  logic                  head_ld;

  always_comb begin
    left    = count_q - CW'(rd_acc);
    head_d  = (left == '0) ? bus.wr_data : mem_q[rd_ptr_d];
    head_ld = rd_acc ? ((left != '0) || wr_acc) : (wr_acc && empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (head_ld) rd_data_q <= head_d;
  end

  assign bus.rd_valid = !empty_q;
`else
  logic rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.rd_data      = rd_data_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo -- directed bench for sync_fifo.
// Default build: DATA_WIDTH=8, FIFO_DEPTH=90, registered read.
// With SYNC_FIFO_FWFT_EN: DATA_WIDTH=16, FIFO_DEPTH=7, fall-through read.
module tb_sync_fifo;
`ifdef SYNC_FIFO_FWFT_EN
  localparam int DW = 16;
  localparam int N  = 7;
`else
  localparam int DW = 8;
  localparam int N  = 90;
`endif
  localparam int AF = N - 4;
  localparam int AE = 4;
  localparam int H  = N / 2;
  localparam int R  = (N > 32) ? 30 : N - 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(N)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] d;
  logic [DW-1:0] exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input int c);
    chk("count",  bus.count,        64'(c));
    chk("empty",  bus.empty,        c == 0);
    chk("full",   bus.full,         c == N);
    chk("afull",  bus.almost_full,  c >= AF);
    chk("aempty", bus.almost_empty, c <= AE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_flags(0);
    chk("rst_ovf",   bus.overflow,  0);
    chk("rst_udf",   bus.underflow, 0);
    chk("rst_valid", bus.rd_valid,  0);
    chk("rst_data",  bus.rd_data,   0);
    rst_n = 1'b1;

    // fill to full, data = index
    for (int i = 0; i < N; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = DW'(i);
      step();
      chk_flags(i + 1);
    end
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head0",  bus.rd_data,  0);
    chk("fwft_valid0", bus.rd_valid, 1);
`endif

    // write into full FIFO
    bus.wr_data = '1;
    step();
    chk("ovf_pulse", bus.overflow, 1);
    chk_flags(N);
    bus.wr_en = 1'b0;
    step();
    chk("ovf_clear", bus.overflow, 0);
    chk_flags(N);

    // drain in order
    for (int i = 0; i < N; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_head",  bus.rd_data,  64'(i));
      chk("fwft_valid", bus.rd_valid, 1);
`endif
      bus.rd_en = 1'b1;
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk("rd_data",  bus.rd_data,  64'(i));
      chk("rd_valid", bus.rd_valid, 1);
`endif
      chk_flags(N - 1 - i);
    end

    // read from empty FIFO
    step();
    chk("udf_pulse",  bus.underflow, 1);
    chk_flags(0);
    chk("udf_valid",  bus.rd_valid,  0);
    chk("udf_hold",   bus.rd_data,   64'(N - 1));
    bus.rd_en = 1'b0;
    step();
    chk("udf_clear",  bus.underflow, 0);
    chk("idle_hold",  bus.rd_data,   64'(N - 1));

    // fill to half, then stream read+write; pointers wrap many times
    d = DW'(16);
    for (int i = 0; i < H; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      q.push_back(d);
      d++;
      step();
    end
    chk_flags(H);
    for (int k = 0; k < 200; k++) begin
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.wr_data = d;
`ifdef SYNC_FIFO_FWFT_EN
      chk("stream_head", bus.rd_data, q[0]);
`endif
      exp_w = q.pop_front();
      q.push_back(d);
      d++;
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk("stream_data", bus.rd_data, exp_w);
`endif
      chk("stream_cnt", bus.count, 64'(H));
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < H; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("tail_head", bus.rd_data, q[0]);
`endif
      exp_w = q.pop_front();
      bus.rd_en = 1'b1;
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk("tail_data", bus.rd_data, exp_w);
`endif
    end
    bus.rd_en = 1'b0;
    chk_flags(0);

    // read+write on empty FIFO: write wins, read rejected
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = DW'('hA5);
    step();
    chk("emp_rw_udf", bus.underflow, 1);
    chk_flags(1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("emp_rw_head",  bus.rd_data,  'hA5);
    chk("emp_rw_valid", bus.rd_valid, 1);
`else
    chk("emp_rw_valid", bus.rd_valid, 0);
`endif
    bus.wr_en = 1'b0;
    step();
`ifndef SYNC_FIFO_FWFT_EN
    chk("emp_rw_data",  bus.rd_data,  'hA5);
    chk("emp_rw_valid", bus.rd_valid, 1);
`endif
    chk("emp_rw_udf0", bus.underflow, 0);
    chk_flags(0);
    bus.rd_en = 1'b0;

    // reset in the middle of a write burst
    for (int i = 0; i < R; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = DW'('h60 + i);
      step();
    end
    chk_flags(R);
    rst_n = 1'b0;
    #1;
    chk_flags(0);
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_data",  bus.rd_data,  0);
    bus.wr_en = 1'b0;
    step();
    rst_n = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = DW'('h3C);
    step();
    bus.wr_en = 1'b0;
    chk_flags(1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_head", bus.rd_data, 'h3C);
`endif
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_rst_data", bus.rd_data, 'h3C);
`endif
    chk_flags(0);

    // read+write on full FIFO: read wins, write rejected
    for (int i = 0; i < N; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = DW'('h40 + i);
      step();
    end
    chk_flags(N);
`ifdef SYNC_FIFO_FWFT_EN
    chk("full_rw_head", bus.rd_data, 'h40);
`endif
    bus.rd_en   = 1'b1;
    bus.wr_data = DW'('hEE);
    step();
    chk("full_rw_ovf", bus.overflow, 1);
    chk_flags(N - 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("full_rw_data", bus.rd_data, 'h40);
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    step();
    chk("full_rw_ovf0", bus.overflow, 0);
    chk_flags(N - 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("full_rw_next", bus.rd_data, 'h41);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
